// File: rtl/traffic_phase_scheduler.sv
// Two-road traffic light phase scheduler with pedestrian request/ack and green hold.
// Define TLC_ALL_RED_EN to insert an all-red clearance after each yellow.
module traffic_phase_scheduler #(
  parameter int GREEN_T   = 6,
  parameter int YELLOW_T  = 2,
  parameter int MIN_GREEN = 2,
  parameter int ALLRED_T  = 1,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ped_req,
  input  logic             hold,
  output logic [1:0]       R,
  output logic [1:0]       Y,
  output logic [1:0]       G,
  output logic             ped_ack,
  output logic [CNT_W-1:0] remain,
  output logic [2:0]       phase
);

  typedef enum logic [2:0] {
    B_GRN = 3'd0,
    B_YEL = 3'd1,
    A_GRN = 3'd2,
    A_YEL = 3'd3,
    AR_A  = 3'd4,
    AR_B  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
`ifdef TLC_ALL_RED_EN
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
`endif

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic             ped_pend;

  logic             is_grn;
  logic             grn_exit;
  logic             clr_done;
  logic [CNT_W-1:0] phase_last;

  always_comb begin
    is_grn     = (state == B_GRN) || (state == A_GRN);
    phase_last = '0;
    case (state)
      B_GRN, A_GRN: phase_last = GREEN_LAST;
      B_YEL, A_YEL: phase_last = YELLOW_LAST;
`ifdef TLC_ALL_RED_EN
      AR_A, AR_B:   phase_last = ALLRED_LAST;
`endif
      default:      phase_last = '0;
    endcase
    // Hold blocks both exits from green; clearance phases ignore hold.
    grn_exit = is_grn && !hold &&
               ((timer == GREEN_LAST) || (ped_pend && (timer >= MIN_LAST)));
    clr_done = !is_grn && (timer == phase_last);
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state    <= B_GRN;
      timer    <= '0;
      ped_pend <= 1'b0;
      ped_ack  <= 1'b0;
    end else begin
      ped_ack <= grn_exit && ped_pend;
      // A request still held during its own ack cycle is not re-latched.
      if (grn_exit && ped_pend)
        ped_pend <= 1'b0;
      else if (ped_req && !ped_ack)
        ped_pend <= 1'b1;

      if (grn_exit || clr_done) begin
        timer <= '0;
        case (state)
          B_GRN:   state <= B_YEL;
`ifdef TLC_ALL_RED_EN
          B_YEL:   state <= AR_A;
          A_YEL:   state <= AR_B;
          AR_A:    state <= A_GRN;
          AR_B:    state <= B_GRN;
`else
          B_YEL:   state <= A_GRN;
          A_YEL:   state <= B_GRN;
`endif
          A_GRN:   state <= A_YEL;
          default: state <= B_GRN;
        endcase
      end else if (!(is_grn && hold)) begin
        timer <= timer + 1'b1;
      end
    end
  end

  always_comb begin
    R = 2'b11;
    Y = 2'b00;
    G = 2'b00;
    case (state)
      B_GRN: begin R = 2'b01; G = 2'b10; end
      B_YEL: begin R = 2'b01; Y = 2'b10; end
      A_GRN: begin R = 2'b10; G = 2'b01; end
      A_YEL: begin R = 2'b10; Y = 2'b01; end
      default: begin R = 2'b11; end
    endcase
    remain = phase_last - timer;
    phase  = state;
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler: a behavioural model pushes the
// expected post-edge outputs, which are popped and compared half a cycle later.
module tb_traffic_phase_scheduler;
  localparam int GREEN_T   = 6;
  localparam int YELLOW_T  = 2;
  localparam int MIN_GREEN = 2;
  localparam int ALLRED_T  = 1;
  localparam int CNT_W     = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ped_req = 1'b0;
  logic             hold = 1'b0;
  logic [1:0]       R, Y, G;
  logic             ped_ack;
  logic [CNT_W-1:0] remain;
  logic [2:0]       phase;

  traffic_phase_scheduler #(
    .GREEN_T(GREEN_T), .YELLOW_T(YELLOW_T), .MIN_GREEN(MIN_GREEN),
    .ALLRED_T(ALLRED_T), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .ped_req(ped_req), .hold(hold),
    .R(R), .Y(Y), .G(G), .ped_ack(ped_ack), .remain(remain), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ph; int r; int y; int g; int ack; int rem;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  int   m_state, m_timer;
  bit   m_pend, m_ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int plen(input int s);
    case (s)
      0, 2:    return GREEN_T;
      1, 3:    return YELLOW_T;
      4, 5:    return ALLRED_T;
      default: return 1;
    endcase
  endfunction

  function automatic int succ(input int s);
    case (s)
`ifdef TLC_ALL_RED_EN
      1: return 4;
      3: return 5;
      4: return 2;
      5: return 0;
`else
      1: return 2;
      3: return 0;
`endif
      0: return 1;
      2: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic exp_t mk_exp(input int s, input int t, input bit a);
    exp_t e;
    e.ph = s; e.ack = a; e.rem = plen(s) - 1 - t;
    case (s)
      0: begin e.r = 1; e.y = 0; e.g = 2; end
      1: begin e.r = 1; e.y = 2; e.g = 0; end
      2: begin e.r = 2; e.y = 0; e.g = 1; end
      3: begin e.r = 2; e.y = 1; e.g = 0; end
      default: begin e.r = 3; e.y = 0; e.g = 0; end
    endcase
    return e;
  endfunction

  task automatic model_reset();
    m_state = 0; m_timer = 0; m_pend = 0; m_ack = 0;
  endtask

  // Advance the model by one edge using the currently driven inputs.
  task automatic model_step();
    bit grn, leave, ack_n;
    grn   = (m_state == 0) || (m_state == 2);
    if (grn)
      leave = !hold && ((m_timer == GREEN_T - 1) ||
                        (m_pend && (m_timer >= MIN_GREEN - 1)));
    else
      leave = (m_timer == plen(m_state) - 1);
    ack_n  = grn && leave && m_pend;
    m_pend = ack_n ? 1'b0 : (m_pend || (ped_req && !m_ack));
    m_ack  = ack_n;
    if (leave) begin
      m_state = succ(m_state);
      m_timer = 0;
    end else if (!(grn && hold)) begin
      m_timer++;
    end
    sb.push_back(mk_exp(m_state, m_timer, m_ack));
  endtask

  task automatic cycle();
    exp_t e;
    model_step();
    @(negedge clk);
    @(posedge clk);
    e = sb.pop_front();
    cyc++;
    $display("cyc %0d req=%0b hold=%0b phase=%0d R=%0d Y=%0d G=%0d ack=%0b remain=%0d",
             cyc, ped_req, hold, phase, R, Y, G, ped_ack, remain);
    check("phase", 32'(phase), e.ph);
    check("R", 32'(R), e.r);
    check("Y", 32'(Y), e.y);
    check("G", 32'(G), e.g);
    check("ped_ack", 32'(ped_ack), e.ack);
    check("remain", 32'(remain), e.rem);
  endtask

  task automatic wait_until(input int s, input int t);
    int n = 0;
    while (!(m_state == s && m_timer == t) && n < 40) begin
      cycle();
      n++;
    end
    check("wait_phase", 32'(m_state == s && m_timer == t), 1);
  endtask

  task automatic req_until_ack();
    int n = 0;
    bit seen = 0;
    ped_req = 1'b1;
    while (!seen && n < 40) begin
      cycle();
      n++;
      if (m_ack) seen = 1;
    end
    check("ack_seen", 32'(seen), 1);
    cycle();
    ped_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_R"}, 32'(R), 1);
    check({tag, "_Y"}, 32'(Y), 0);
    check({tag, "_G"}, 32'(G), 2);
    check({tag, "_remain"}, 32'(remain), GREEN_T - 1);
    check({tag, "_phase"}, 32'(phase), 0);
    check({tag, "_ack"}, 32'(ped_ack), 0);
  endtask

  initial begin
    bit drop_next;
    model_reset();
    #2;
    check_reset_outputs("reset");
    #5 rst = 1'b1;

    // Free-running: two full periods with no requests
    repeat (32) cycle();

    // Request at start of B green shortens it to MIN_GREEN
    wait_until(0, 0);
    req_until_ack();
    repeat (4) cycle();

    // Request during B yellow is served in the following A green
    wait_until(1, 0);
    req_until_ack();
    repeat (4) cycle();

    // Hold freezes green timer
    wait_until(0, 3);
    hold = 1'b1;
    repeat (10) cycle();
    check("hold_remain", 32'(remain), GREEN_T - 4);
    hold = 1'b0;
    repeat (6) cycle();

    // Hold is ignored in yellow
    wait_until(3, 0);
    hold = 1'b1;
    repeat (3) cycle();
    hold = 1'b0;
    repeat (4) cycle();

    // Asynchronous reset mid A green, between edges
    wait_until(2, 2);
    #1 rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    #1 rst = 1'b1;
    repeat (20) cycle();

    // Random requests and holds
    drop_next = 0;
    repeat (150) begin
      hold = ($urandom_range(0, 3) == 0);
      if (ped_req && drop_next) begin
        ped_req = 1'b0;
        drop_next = 0;
      end else if (!ped_req && $urandom_range(0, 7) == 0) begin
        ped_req = 1'b1;
      end
      cycle();
      if (ped_req && m_ack) drop_next = 1;
    end
    hold = 1'b0;
    ped_req = 1'b0;
    repeat (4) cycle();

    check("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
